// File: rtl/vga_raster_engine.sv
// VGA raster engine: sync/blank timing, framebuffer address generation,
// palette lookup and double-buffered page flipping in the pixel clock domain.
module vga_raster_engine #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int INDEX_W  = 3,
  parameter int COLOR_W  = 24,
  parameter int ADDR_W   = 20
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [ADDR_W-1:0]      fb_rd_addr,
  input  logic [INDEX_W-1:0]     fb_rd_data,
  input  logic                   pal_we,
  input  logic [INDEX_W-1:0]     pal_waddr,
  input  logic [COLOR_W-1:0]     pal_wdata,
  input  logic                   flip_req,
  output logic                   flip_ack,
  output logic                   page_sel,
  output logic                   oHS,
  output logic                   oVS,
  output logic                   oBLANK_n,
  output logic [COLOR_W/3-1:0]   b_data,
  output logic [COLOR_W/3-1:0]   g_data,
  output logic [COLOR_W/3-1:0]   r_data,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CW      = COLOR_W / 3;
  localparam int PAL_N   = 1 << INDEX_W;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [ADDR_W-1:0] PAGE1_BASE = ADDR_W'(H_ACTIVE * V_ACTIVE);

  // Both pages must be addressable without wrapping onto each other.
  if (longint'(2) * H_ACTIVE * V_ACTIVE > (longint'(1) << ADDR_W)) begin : g_addr_check
    $error("ADDR_W too small for two framebuffer pages");
  end
  if (COLOR_W % 3 != 0) begin : g_color_check
    $error("COLOR_W must split evenly into B, G and R");
  end

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic blank_n;
    logic fstart;
  } timing_t;

  localparam timing_t TIM_RST = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0, fstart: 1'b0};

  logic [HW-1:0]      h_q, h_d;
  logic [VW-1:0]      v_q, v_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               page_q, page_d;
  logic               pend_q, pend_d;
  logic               ack_q, ack_d;
  timing_t            tim_q [3];
  timing_t            tim_d;
  logic [COLOR_W-1:0] colour_q, colour_d;
  logic [COLOR_W-1:0] pal_q [PAL_N];

  logic h_wrap;
  logic act_0;
  logic at_origin;
  logic flip_apply;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    h_wrap    = (h_q == H_LAST);
    h_d       = h_wrap ? '0 : h_q + HW'(1);
    v_d       = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    end

    act_0     = (h_q < H_ACT) && (v_q < V_ACT);
    at_origin = (h_q == '0) && (v_q == '0);

    tim_d.hs_n    = !((h_q >= HS_BEG) && (h_q < HS_END));
    tim_d.vs_n    = !((v_q >= VS_BEG) && (v_q < VS_END));
    tim_d.blank_n = act_0;
    tim_d.fstart  = at_origin;

    // Linear address walk: one increment per visible pixel, reloaded per frame.
    addr_d = addr_q;
    if (at_origin) begin
      addr_d = page_q ? PAGE1_BASE : '0;
    end else if (act_0) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    // A request arriving on the apply cycle itself survives for the next frame.
    flip_apply = (h_q == '0) && (v_q == V_ACT) && pend_q;
    pend_d     = (pend_q && !flip_apply) || flip_req;
    page_d     = page_q ^ flip_apply;
    ack_d      = flip_apply;

    colour_d = tim_q[1].blank_n ? pal_q[fb_rd_data] : '0;
  end

  // NOTE: state registers use non-blocking assignments so each one samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_q      <= '0;
      v_q      <= '0;
      addr_q   <= '0;
      page_q   <= 1'b0;
      pend_q   <= 1'b0;
      ack_q    <= 1'b0;
      colour_q <= '0;
      for (int i = 0; i < 3; i++) begin
        tim_q[i] <= TIM_RST;
      end
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      addr_q   <= addr_d;
      page_q   <= page_d;
      pend_q   <= pend_d;
      ack_q    <= ack_d;
      colour_q <= colour_d;
      tim_q[0] <= tim_d;
      tim_q[1] <= tim_q[0];
      tim_q[2] <= tim_q[1];
    end
  end

  // NOTE: the palette is a small register file rather than a RAM macro, so
  // clearing it under reset is legal and gives a defined black palette.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PAL_N; i++) begin
        pal_q[i] <= '0;
      end
    end else if (pal_we) begin
      pal_q[pal_waddr] <= pal_wdata;
    end
  end

  assign fb_rd_addr  = addr_q;
  assign page_sel    = page_q;
  assign flip_ack    = ack_q;
  assign oHS         = tim_q[2].hs_n;
  assign oVS         = tim_q[2].vs_n;
  assign oBLANK_n    = tim_q[2].blank_n;
  assign frame_start = tim_q[2].fstart;
  assign b_data      = colour_q[COLOR_W-1 -: CW];
  assign g_data      = colour_q[2*CW-1 -: CW];
  assign r_data      = colour_q[CW-1:0];

endmodule

// File: tb/tb_vga_raster_engine.sv
// Scoreboard bench for vga_raster_engine on a reduced 12 x 7 raster
// (8x4 visible, 84 clocks per frame, two 32-word pages).
module tb_vga_raster_engine;

  localparam int HT    = 12;
  localparam int HA    = 8;
  localparam int VA    = 4;
  localparam int FRAME = 84;

  localparam logic [23:0] PAL_INIT [8] = '{
    24'h102030, 24'hFF0000, 24'h00FF00, 24'h0000FF,
    24'h123456, 24'hABCDEF, 24'h7F7F7F, 24'hFFFFFF
  };
  localparam logic [23:0] NEW2 = 24'h55AA33;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  fb_rd_addr;
  logic [2:0]  fb_rd_data = '0;
  logic        pal_we = 1'b0;
  logic [2:0]  pal_waddr = '0;
  logic [23:0] pal_wdata = '0;
  logic        flip_req = 1'b0;
  logic        flip_ack, page_sel, oHS, oVS, oBLANK_n, frame_start;
  logic [7:0]  b_data, g_data, r_data;

  vga_raster_engine #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .INDEX_W(3), .COLOR_W(24), .ADDR_W(6)
  ) dut (
    .clock(clock), .reset(reset),
    .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
    .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
    .flip_req(flip_req), .flip_ack(flip_ack), .page_sel(page_sel),
    .oHS(oHS), .oVS(oVS), .oBLANK_n(oBLANK_n),
    .b_data(b_data), .g_data(g_data), .r_data(r_data),
    .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  // Framebuffer model: one-clock read latency; page 1 holds indices XORed with 1.
  always @(posedge clock) fb_rd_data <= fb_rd_addr[2:0] ^ {2'b00, fb_rd_addr[5]};

  // Clocks since reset release: cycle n is the interval after edge n.
  int cyc;
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct packed {
    logic        hs_n;
    logic        vs_n;
    logic        blank_n;
    logic        fs;
    logic [23:0] rgb;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [23:0] pal_exp [8];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: every clock out of reset is one presented output vector.
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en && sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check($sformatf("timing@%0d", cyc),
              64'({oHS, oVS, oBLANK_n, frame_start}),
              64'({mon_e.hs_n, mon_e.vs_n, mon_e.blank_n, mon_e.fs}));
        check($sformatf("colour@%0d", cyc),
              64'({b_data, g_data, r_data}), 64'(mon_e.rgb));
      end
    end
  end

  task automatic push_reset_cycles();
    exp_t e;
    e = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0, fs: 1'b0, rgb: 24'h0};
    for (int i = 0; i < 3; i++) sb_q.push_back(e);
  endtask

  // Expected outputs for one frame; pixels up to ov_last that use entry
  // ov_idx see ov_val (the palette value before a mid-frame write).
  task automatic push_frame(input bit page, input int ov_idx,
                            input logic [23:0] ov_val, input int ov_last);
    for (int t = 0; t < FRAME; t++) begin
      int   h, v, idx;
      exp_t e;
      h         = t % HT;
      v         = t / HT;
      idx       = h ^ int'(page);
      e.blank_n = (h < HA) && (v < VA);
      e.hs_n    = !(h == 9 || h == 10);
      e.vs_n    = (v != 5);
      e.fs      = (t == 0);
      e.rgb     = 24'h0;
      if (e.blank_n) begin
        e.rgb = (idx == ov_idx && v * HA + h <= ov_last) ? ov_val : pal_exp[idx];
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    do begin
      @(posedge clock);
      #2;
      guard++;
    end while (cyc < n && guard < 2000);
    if (cyc != n) begin
      errors++;
      $display("FAIL wait_cyc: reached cycle %0d, wanted %0d", cyc, n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 64'(fb_rd_addr), 64'd0);
    check({tag, "_page"}, 64'(page_sel), 64'd0);
    check({tag, "_ack"},  64'(flip_ack), 64'd0);
    check({tag, "_sync"}, 64'({oHS, oVS, oBLANK_n, frame_start}), 64'hC);
    check({tag, "_rgb"},  64'({b_data, g_data, r_data}), 64'd0);
  endtask

  task automatic pulse_flip(input int k);
    wait_cyc(k);
    flip_req = 1'b1;
    wait_cyc(k + 1);
    flip_req = 1'b0;
  endtask

  task automatic check_flip(input int k, input bit ack, input bit page);
    wait_cyc(k);
    check($sformatf("flip_ack@%0d", k), 64'(flip_ack), 64'(ack));
    check($sformatf("page_sel@%0d", k), 64'(page_sel), 64'(page));
  endtask

  task automatic check_addr(input int k, input int exp);
    wait_cyc(k);
    check($sformatf("addr@%0d", k), 64'(fb_rd_addr), 64'(exp));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) pal_exp[i] = 24'h0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    check_reset_outputs("por");
    push_reset_cycles();
    push_frame(1'b0, -1, 24'h0, -1);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Frame 0: black palette; full address walk; load palette during blanking.
    for (int k = 1; k <= 84; k++) begin
      int n, h, v, exp_a;
      wait_cyc(k);
      pal_we = 1'b0;
      if (k >= 50 && k <= 57) begin
        pal_we          = 1'b1;
        pal_waddr       = 3'(k - 50);
        pal_wdata       = PAL_INIT[k - 50];
        pal_exp[k - 50] = PAL_INIT[k - 50];
      end
      n     = k - 1;
      h     = n % HT;
      v     = n / HT;
      exp_a = (v < VA) ? v * HA + ((h < HA) ? h : HA - 1) : 31;
      check($sformatf("addr@%0d", k), 64'(fb_rd_addr), 64'(exp_a));
    end
    pal_exp[2] = NEW2;
    push_frame(1'b0, 2, PAL_INIT[2], 2);

    // Frame 1 (base 84): address wraps to 0, entry 2 rewritten while displayed.
    check_addr(85, 0);
    wait_cyc(88);
    pal_we    = 1'b1;
    pal_waddr = 3'd2;
    pal_wdata = NEW2;
    wait_cyc(89);
    pal_we = 1'b0;
    pulse_flip(96);
    pulse_flip(108);
    check_flip(131, 1'b0, 1'b0);
    check_flip(132, 1'b0, 1'b0);
    check_flip(133, 1'b1, 1'b1);
    check_flip(134, 1'b0, 1'b1);
    check_addr(168, 31);
    push_frame(1'b1, -1, 24'h0, -1);

    // Frame 2 (base 168): page 1; a request on the apply cycle stays pending.
    check_addr(169, 32);
    check_addr(176, 39);
    pulse_flip(180);
    wait_cyc(216);
    flip_req = 1'b1;
    check($sformatf("flip_ack@%0d", 216), 64'(flip_ack), 64'd0);
    check($sformatf("page_sel@%0d", 216), 64'(page_sel), 64'd1);
    wait_cyc(217);
    flip_req = 1'b0;
    check($sformatf("flip_ack@%0d", 217), 64'(flip_ack), 64'd1);
    check($sformatf("page_sel@%0d", 217), 64'(page_sel), 64'd0);
    wait_cyc(252);
    push_frame(1'b0, -1, 24'h0, -1);

    // Frame 3 (base 252): carried-over request flips again.
    check_addr(253, 0);
    check_flip(300, 1'b0, 1'b0);
    check_flip(301, 1'b1, 1'b1);
    wait_cyc(336);
    push_frame(1'b1, -1, 24'h0, -1);

    // Frame 4 (base 336): request pending, then reset on line 3.
    check_addr(337, 32);
    pulse_flip(348);
    wait_cyc(372);
    mon_en = 1'b0;
    reset  = 1'b1;
    sb_q.delete();
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(posedge clock);
    #2;
    check_reset_outputs("mid_rst_hold");
    for (int i = 0; i < 8; i++) pal_exp[i] = 24'h0;
    push_reset_cycles();
    push_frame(1'b0, -1, 24'h0, -1);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Restart: origin, page 0, pending flip discarded.
    check_addr(1, 0);
    check_flip(49, 1'b0, 1'b0);
    check_flip(50, 1'b0, 1'b0);
    check_addr(85, 0);
    wait_cyc(87);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
